// File: rtl/fib_sequencer.sv
// fib_sequencer: runs BCD->binary, Fibonacci and binary->BCD units in turn
// and latches the 4-digit BCD result for the display, flagging bad input,
// results that do not fit in four digits, and sub-units that never answer.
module fib_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_N          = 20
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [7:0]  iterations_bcd_i,
  output logic        bcd2bin_start_o,
  output logic [7:0]  bcd2bin_bcd_o,
  input  logic        bcd2bin_done_i,
  input  logic [6:0]  bcd2bin_bin_i,
  output logic        fib_start_o,
  output logic [4:0]  fib_n_o,
  input  logic        fib_done_i,
  input  logic [13:0] fib_result_i,
  output logic        bin2bcd_start_o,
  output logic [13:0] bin2bcd_bin_o,
  input  logic        bin2bcd_done_i,
  input  logic [15:0] bin2bcd_bcd_i,
  output logic [15:0] display_bcd_o,
  output logic        ready_o,
  output logic        done_tick_o,
  output logic        overflow_o,
  output logic        error_o
);

  localparam int unsigned WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0]  MAX_N_BIN  = 7'(MAX_N);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] DISP_ERR   = 16'hEEEE;
  localparam logic [15:0] DISP_OVF   = 16'h9999;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_IN  = 3'd1,
    FIB      = 3'd2,
    CONV_OUT = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [7:0]          bcd_d;
  logic [4:0]          n_d;
  logic [13:0]         bin_d;
  logic [15:0]         disp_d;
  logic                ovf_d, err_d;
  logic                timeout_c;
  logic                bad_bcd_c;

  // The watchdog fires on the cycle that completes TIMEOUT_CYCLES in a unit state
  assign timeout_c = (wdog_q == WDOG_LAST);
  assign bad_bcd_c = (iterations_bcd_i[7:4] > 4'd9) || (iterations_bcd_i[3:0] > 4'd9);

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state, operand/result updates and watchdog; a done beats a timeout
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd2bin_bcd_o;
    n_d     = fib_n_o;
    bin_d   = bin2bcd_bin_o;
    disp_d  = display_bcd_o;
    ovf_d   = overflow_o;
    err_d   = error_o;
    wdog_d  = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          bcd_d = iterations_bcd_i;
          ovf_d = 1'b0;
          err_d = 1'b0;
          if (bad_bcd_c) begin
            err_d   = 1'b1;
            disp_d  = DISP_ERR;
            state_d = FINISH;
          end else begin
            state_d = CONV_IN;
          end
        end
      end
      CONV_IN: begin
        if (bcd2bin_done_i && !bcd2bin_start_o) begin
          if (bcd2bin_bin_i > MAX_N_BIN) begin
            ovf_d   = 1'b1;
            disp_d  = DISP_OVF;
            state_d = FINISH;
          end else begin
            n_d     = 5'(bcd2bin_bin_i);
            state_d = FIB;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          disp_d  = DISP_ERR;
          state_d = FINISH;
        end
      end
      FIB: begin
        if (fib_done_i && !fib_start_o) begin
          bin_d   = fib_result_i;
          state_d = CONV_OUT;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          disp_d  = DISP_ERR;
          state_d = FINISH;
        end
      end
      CONV_OUT: begin
        if (bin2bcd_done_i && !bin2bcd_start_o) begin
          disp_d  = bin2bcd_bcd_i;
          state_d = FINISH;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          disp_d  = DISP_ERR;
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == CONV_IN || state_q == FIB || state_q == CONV_OUT) &&
        (state_d == state_q)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Registered outputs: status flags mirror the state being entered
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wdog_q          <= '0;
      bcd2bin_bcd_o   <= '0;
      fib_n_o         <= '0;
      bin2bcd_bin_o   <= '0;
      display_bcd_o   <= '0;
      overflow_o      <= 1'b0;
      error_o         <= 1'b0;
      ready_o         <= 1'b1;
      done_tick_o     <= 1'b0;
      bcd2bin_start_o <= 1'b0;
      fib_start_o     <= 1'b0;
      bin2bcd_start_o <= 1'b0;
    end else begin
      wdog_q          <= wdog_d;
      bcd2bin_bcd_o   <= bcd_d;
      fib_n_o         <= n_d;
      bin2bcd_bin_o   <= bin_d;
      display_bcd_o   <= disp_d;
      overflow_o      <= ovf_d;
      error_o         <= err_d;
      ready_o         <= (state_d == IDLE);
      done_tick_o     <= (state_d == FINISH);
      bcd2bin_start_o <= (state_d == CONV_IN)  && (state_q != CONV_IN);
      fib_start_o     <= (state_d == FIB)      && (state_q != FIB);
      bin2bcd_start_o <= (state_d == CONV_OUT) && (state_q != CONV_OUT);
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Testbench for fib_sequencer: unit models with random latency, a
// reference model of the expected outcome, and cycle-accurate checks.
module tb_fib_sequencer;

  localparam int unsigned TO   = 8;
  localparam int unsigned MAXN = 20;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        start_i;
  logic [7:0]  iterations_bcd_i;
  logic        bcd2bin_start_o;
  logic [7:0]  bcd2bin_bcd_o;
  logic        bcd2bin_done_i;
  logic [6:0]  bcd2bin_bin_i;
  logic        fib_start_o;
  logic [4:0]  fib_n_o;
  logic        fib_done_i;
  logic [13:0] fib_result_i;
  logic        bin2bcd_start_o;
  logic [13:0] bin2bcd_bin_o;
  logic        bin2bcd_done_i;
  logic [15:0] bin2bcd_bcd_i;
  logic [15:0] display_bcd_o;
  logic        ready_o;
  logic        done_tick_o;
  logic        overflow_o;
  logic        error_o;

  int n_checks = 0;
  int n_errors = 0;

  fib_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_N(MAXN)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
    .iterations_bcd_i(iterations_bcd_i),
    .bcd2bin_start_o(bcd2bin_start_o), .bcd2bin_bcd_o(bcd2bin_bcd_o),
    .bcd2bin_done_i(bcd2bin_done_i), .bcd2bin_bin_i(bcd2bin_bin_i),
    .fib_start_o(fib_start_o), .fib_n_o(fib_n_o),
    .fib_done_i(fib_done_i), .fib_result_i(fib_result_i),
    .bin2bcd_start_o(bin2bcd_start_o), .bin2bcd_bin_o(bin2bcd_bin_o),
    .bin2bcd_done_i(bin2bcd_done_i), .bin2bcd_bcd_i(bin2bcd_bcd_i),
    .display_bcd_o(display_bcd_o), .ready_o(ready_o),
    .done_tick_o(done_tick_o), .overflow_o(overflow_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fib(input int n);
    int a = 0;
    int b = 1;
    int t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One full operation; cycle k counts from the cycle start_i is presented (k=0)
  task automatic run_op(input logic [7:0] bcd, input bit hang, input bit pokes);
    int l1 = int'($urandom_range(1, TO - 1));
    int l2 = int'($urandom_range(1, TO - 1));
    int l3 = int'($urandom_range(1, TO - 1));
    int th = int'(bcd[7:4]);
    int on = int'(bcd[3:0]);
    int n  = th * 10 + on;
    bit bad = (th > 9) || (on > 9);
    int s1 = -1, s2 = -1, s3 = -1, tick = -1;
    int c1 = 0, c2 = 0, c3 = 0;
    int e_tick, e_c1, e_c2, e_c3;
    logic [15:0] e_disp;
    logic e_ovf, e_err;

    e_ovf = 1'b0;
    e_err = 1'b0;
    if (bad) begin
      e_disp = 16'hEEEE; e_err = 1'b1; e_tick = 1; e_c1 = 0; e_c2 = 0; e_c3 = 0;
    end else if (n > int'(MAXN)) begin
      e_disp = 16'h9999; e_ovf = 1'b1; e_tick = 2 + l1; e_c1 = 1; e_c2 = 0; e_c3 = 0;
    end else if (hang) begin
      e_disp = 16'hEEEE; e_err = 1'b1; e_tick = 2 + l1 + int'(TO); e_c1 = 1; e_c2 = 1; e_c3 = 0;
    end else begin
      e_disp = to_bcd(fib(n)); e_tick = 4 + l1 + l2 + l3; e_c1 = 1; e_c2 = 1; e_c3 = 1;
    end

    @(negedge clk_i);
    start_i = 1'b1;
    iterations_bcd_i = bcd;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      bcd2bin_done_i = 1'b0;
      fib_done_i = 1'b0;
      bin2bcd_done_i = 1'b0;
      if (k == 1) check("ready_busy", 32'(ready_o), 32'd0);
      if (bcd2bin_start_o) begin c1++; s1 = k; check("bcd2bin_bcd", 32'(bcd2bin_bcd_o), 32'(bcd)); end
      if (fib_start_o) begin c2++; s2 = k; check("fib_n", 32'(fib_n_o), 32'(n)); end
      if (bin2bcd_start_o) begin c3++; s3 = k; check("bin2bcd_bin", 32'(bin2bcd_bin_o), 32'(fib(n))); end
      if (done_tick_o) begin tick = k; break; end
      if (s1 > 0 && k == s1 + l1) begin bcd2bin_done_i = 1'b1; bcd2bin_bin_i = 7'(n); end
      if (s2 > 0 && k == s2 + l2 && !hang) begin fib_done_i = 1'b1; fib_result_i = 14'(fib(n)); end
      if (s3 > 0 && k == s3 + l3) begin bin2bcd_done_i = 1'b1; bin2bcd_bcd_i = to_bcd(fib(n)); end
      if (pokes && k == 1) begin fib_done_i = 1'b1; fib_result_i = 14'h3FFF; end
      if (pokes && s2 > 0 && k == s2 + 1) begin start_i = 1'b1; iterations_bcd_i = 8'h05; end
    end
    check("tick_cycle", 32'(tick), 32'(e_tick));
    check("bcd2bin_pulses", 32'(c1), 32'(e_c1));
    check("fib_pulses", 32'(c2), 32'(e_c2));
    check("bin2bcd_pulses", 32'(c3), 32'(e_c3));
    check("display", 32'(display_bcd_o), 32'(e_disp));
    check("overflow", 32'(overflow_o), 32'(e_ovf));
    check("error", 32'(error_o), 32'(e_err));
    @(negedge clk_i);
    start_i = 1'b0;
    bcd2bin_done_i = 1'b0;
    fib_done_i = 1'b0;
    bin2bcd_done_i = 1'b0;
    check("tick_one_cycle", 32'(done_tick_o), 32'd0);
    check("ready_back", 32'(ready_o), 32'd1);
    check("display_hold", 32'(display_bcd_o), 32'(e_disp));
    check("operand_hold", 32'(bcd2bin_bcd_o), 32'(bcd));
  endtask

  // Reset asserted while the Fibonacci unit is busy
  task automatic reset_mid_fib();
    int seen = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    iterations_bcd_i = 8'h15;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    bcd2bin_done_i = 1'b1;
    bcd2bin_bin_i = 7'd15;
    @(negedge clk_i);
    bcd2bin_done_i = 1'b0;
    check("fib_start_pre_reset", 32'(fib_start_o), 32'd1);
    @(negedge clk_i);
    reset_ni = 1'b0;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_display", 32'(display_bcd_o), 32'd0);
    check("rst_fib_n", 32'(fib_n_o), 32'd0);
    check("rst_bcd_op", 32'(bcd2bin_bcd_o), 32'd0);
    check("rst_flags", 32'({done_tick_o, error_o, overflow_o, fib_start_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (done_tick_o || bcd2bin_start_o || fib_start_o || bin2bcd_start_o || !ready_o) seen++;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [7:0] r_bcd;
    reset_ni = 1'b0;
    start_i = 1'b0;
    iterations_bcd_i = '0;
    bcd2bin_done_i = 1'b0;
    bcd2bin_bin_i = '0;
    fib_done_i = 1'b0;
    fib_result_i = '0;
    bin2bcd_done_i = 1'b0;
    bin2bcd_bcd_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_display", 32'(display_bcd_o), 32'd0);
    check("reset_flags", 32'({done_tick_o, error_o, overflow_o}), 32'd0);
    check("reset_starts", 32'({bcd2bin_start_o, fib_start_o, bin2bcd_start_o}), 32'd0);
    reset_ni = 1'b1;
    @(negedge clk_i);

    run_op(8'h12, 1'b0, 1'b0);
    run_op(8'h00, 1'b0, 1'b0);
    run_op(8'h20, 1'b0, 1'b0);
    run_op(8'h21, 1'b0, 1'b0);
    run_op(8'h1A, 1'b0, 1'b0);
    run_op(8'h07, 1'b1, 1'b0);
    run_op(8'h12, 1'b0, 1'b1);
    reset_mid_fib();

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        8:       r_bcd = 8'($urandom);
        9:       r_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(10, 15))};
        7:       r_bcd = {4'($urandom_range(3, 9)), 4'($urandom_range(0, 9))};
        default: r_bcd = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      endcase
      run_op(r_bcd, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
